// File: rtl/axi_lite_master_read_if.sv
// AXI4-Lite read channels plus the local user request/response port.
// master: the read initiator side; slave: the far end and the user.
interface axi_lite_master_read_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              M_AXIL_ARVALID;
    logic              M_AXIL_ARREADY;
    logic [ADDR_W-1:0] M_AXIL_ARADDR;
    logic [2:0]        M_AXIL_ARPROT;
    logic              M_AXIL_RVALID;
    logic              M_AXIL_RREADY;
    logic [DATA_W-1:0] M_AXIL_RDATA;
    logic [1:0]        M_AXIL_RRESP;

    logic              user_port_rd_req;
    logic              user_port_rd_ready;
    logic [ADDR_W-1:0] user_port_rd_addr;
    logic              user_port_rd_valid;
    logic [DATA_W-1:0] user_port_rd_data;
    logic [1:0]        user_port_rd_resp;
    logic              user_port_rd_timeout;

    modport master (
        output M_AXIL_ARVALID,
        input  M_AXIL_ARREADY,
        output M_AXIL_ARADDR,
        output M_AXIL_ARPROT,
        input  M_AXIL_RVALID,
        output M_AXIL_RREADY,
        input  M_AXIL_RDATA,
        input  M_AXIL_RRESP,
        input  user_port_rd_req,
        output user_port_rd_ready,
        input  user_port_rd_addr,
        output user_port_rd_valid,
        output user_port_rd_data,
        output user_port_rd_resp,
        output user_port_rd_timeout
    );

    modport slave (
        input  M_AXIL_ARVALID,
        output M_AXIL_ARREADY,
        input  M_AXIL_ARADDR,
        input  M_AXIL_ARPROT,
        output M_AXIL_RVALID,
        input  M_AXIL_RREADY,
        output M_AXIL_RDATA,
        output M_AXIL_RRESP,
        output user_port_rd_req,
        input  user_port_rd_ready,
        output user_port_rd_addr,
        input  user_port_rd_valid,
        input  user_port_rd_data,
        input  user_port_rd_resp,
        input  user_port_rd_timeout
    );
endinterface

// File: rtl/axi_lite_master_read.sv
// AXI4-Lite single-outstanding read initiator with a local user port.
// Optional hung-slave watchdog enabled by defining AXIL_MRD_TIMEOUT_EN.
module axi_lite_master_read #(
    parameter int         ADDR_W         = 32,
    parameter int         DATA_W         = 32,
    parameter logic [2:0] ARPROT_VAL     = 3'b000,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic                   M_AXIL_ACLK,
    input  logic                   M_AXIL_ARESET,
    axi_lite_master_read_if.master bus
);
    localparam int LSB = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << LSB;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_dw
        $error("axi_lite_master_read: DATA_W must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("axi_lite_master_read: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              rready_q, rready_d;
    logic              rd_ready_q, rd_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [1:0]        rd_resp_q, rd_resp_d;

    logic ar_hs;
    logic r_hs;
    logic expired;
    logic abort;

    assign ar_hs = arvalid_q && bus.M_AXIL_ARREADY;
    assign r_hs  = rready_q && bus.M_AXIL_RVALID;

`ifdef AXIL_MRD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timer_q, timer_d;
    logic          rd_timeout_q, rd_timeout_d;

    // Timer sits at zero in IDLE so it is clear on entry to ADDR, and
    // saturates so a limit-cycle AR handshake leaves DATA already expired.
    assign expired = (timer_q >= T_LAST);

    always_comb begin
        timer_d      = timer_q;
        rd_timeout_d = abort;
        if (state_q == S_IDLE) begin
            timer_d = '0;
        end else if ((state_q == S_ADDR || state_q == S_DATA)
                     && timer_q != T_SAT) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge M_AXIL_ACLK or posedge M_AXIL_ARESET) begin
        if (M_AXIL_ARESET) begin
            timer_q      <= '0;
            rd_timeout_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            rd_timeout_q <= rd_timeout_d;
        end
    end

    assign bus.user_port_rd_timeout = rd_timeout_q;
`else
    assign expired = 1'b0;
    assign bus.user_port_rd_timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        rready_d   = rready_q;
        rd_ready_d = rd_ready_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_resp_d  = rd_resp_q;
        abort      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.user_port_rd_req && rd_ready_q) begin
                    araddr_d   = bus.user_port_rd_addr & ADDR_MASK;
                    arvalid_d  = 1'b1;
                    rd_ready_d = 1'b0;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    rd_data_d  = bus.M_AXIL_RDATA;
                    rd_resp_d  = bus.M_AXIL_RRESP;
                    rready_d   = 1'b0;
                    rd_valid_d = 1'b1;
                    state_d    = S_RESP;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            S_RESP: begin
                rd_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                arvalid_d  = 1'b0;
                rready_d   = 1'b0;
                rd_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase

        // Watchdog abort drops ARVALID mid-handshake to recover a hung slave.
        if (abort) begin
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            rd_data_d  = '0;
            rd_resp_d  = 2'b10;
            rd_valid_d = 1'b1;
            state_d    = S_RESP;
        end
    end

    always_ff @(posedge M_AXIL_ACLK or posedge M_AXIL_ARESET) begin
        if (M_AXIL_ARESET) begin
            state_q    <= S_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            rready_q   <= 1'b0;
            rd_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_resp_q  <= '0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            rready_q   <= rready_d;
            rd_ready_q <= rd_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_resp_q  <= rd_resp_d;
        end
    end

    assign bus.M_AXIL_ARVALID     = arvalid_q;
    assign bus.M_AXIL_ARADDR      = araddr_q;
    assign bus.M_AXIL_ARPROT      = ARPROT_VAL;
    assign bus.M_AXIL_RREADY      = rready_q;
    assign bus.user_port_rd_ready = rd_ready_q;
    assign bus.user_port_rd_valid = rd_valid_q;
    assign bus.user_port_rd_data  = rd_data_q;
    assign bus.user_port_rd_resp  = rd_resp_q;

`ifndef SYNTHESIS
    a_no_rready_with_ar : assert property (
        @(posedge M_AXIL_ACLK) disable iff (M_AXIL_ARESET)
        !(arvalid_q && rready_q));
    a_valid_pulse : assert property (
        @(posedge M_AXIL_ACLK) disable iff (M_AXIL_ARESET)
        rd_valid_q |=> !rd_valid_q);
`endif
endmodule

// File: tb/tb_axi_lite_master_read.sv
// Randomized self-checking bench for axi_lite_master_read.
// Define AXIL_MRD_TIMEOUT_EN to also exercise the watchdog (limit 16).
module tb_axi_lite_master_read;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  axi_lite_master_read_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

  axi_lite_master_read #(
    .ADDR_W(32), .DATA_W(32), .ARPROT_VAL(3'b000), .TIMEOUT_CYCLES(T)
  ) dut (
    .M_AXIL_ACLK(clk),
    .M_AXIL_ARESET(rst),
    .bus(ifc.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int lat;
    int pulses;
    int ar_hs;
    int ar_high;
    int acc_cyc;
    bit ar_stable;
    bit rready_early;
    logic [31:0] araddr;
    logic [31:0] data;
    logic [1:0] resp;
    logic tmo;
    logic ready_after;
  } obs_t;

  // Drives one user request and acts as an AXI slave with given delays.
  // Starts and ends on a negedge; returns what it observed.
  task automatic run_txn(input logic [31:0] a, input int ar_dly,
                         input int r_dly, input logic [31:0] d,
                         input logic [1:0] rs, input bit busy,
                         output obs_t o);
    int ar_seen;
    int ar_cyc;
    bit r_done;
    bit fin;
    int w;
    o = '{default: 0};
    o.lat = -1;
    o.ar_stable = 1'b1;
    ar_seen = 0;
    ar_cyc = -1;
    r_done = 1'b0;
    fin = 1'b0;
    w = 0;
    while (ifc.user_port_rd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    ifc.user_port_rd_req = 1'b1;
    ifc.user_port_rd_addr = a;
    o.acc_cyc = cyc;
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clk);
      if (ifc.M_AXIL_RREADY === 1'b1 && ar_cyc < 0) o.rready_early = 1'b1;
      if (ifc.M_AXIL_ARVALID === 1'b1) begin
        if (o.ar_high == 0) o.araddr = ifc.M_AXIL_ARADDR;
        else if (ifc.M_AXIL_ARADDR !== o.araddr) o.ar_stable = 1'b0;
        o.ar_high++;
        if (ar_seen >= ar_dly) begin
          ifc.M_AXIL_ARREADY = 1'b1;
          o.ar_hs++;
          ar_cyc = c;
        end else begin
          ifc.M_AXIL_ARREADY = 1'b0;
          ar_seen++;
        end
      end else begin
        ifc.M_AXIL_ARREADY = 1'b0;
      end
      if (ar_cyc < 0 || c == ar_cyc || r_done) begin
        ifc.M_AXIL_RVALID = 1'($urandom_range(0, 1));
        ifc.M_AXIL_RDATA = $urandom;
        ifc.M_AXIL_RRESP = 2'($urandom_range(0, 3));
      end else if (c - ar_cyc - 1 >= r_dly) begin
        ifc.M_AXIL_RVALID = 1'b1;
        ifc.M_AXIL_RDATA = d;
        ifc.M_AXIL_RRESP = rs;
        if (ifc.M_AXIL_RREADY === 1'b1) r_done = 1'b1;
      end else begin
        ifc.M_AXIL_RVALID = 1'b0;
        ifc.M_AXIL_RDATA = $urandom;
      end
      if (ifc.user_port_rd_valid === 1'b1) begin
        o.pulses++;
        if (o.lat < 0) begin
          o.lat = c;
          o.data = ifc.user_port_rd_data;
          o.resp = ifc.user_port_rd_resp;
          o.tmo = ifc.user_port_rd_timeout;
        end
      end
      if (o.lat >= 0 && c == o.lat + 1) begin
        o.ready_after = ifc.user_port_rd_ready;
        fin = 1'b1;
      end
      ifc.user_port_rd_req = busy && (o.lat < 0);
      ifc.user_port_rd_addr = busy ? 32'h20 : a;
    end
    ifc.user_port_rd_req = 1'b0;
    ifc.M_AXIL_ARREADY = 1'b0;
    ifc.M_AXIL_RVALID = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.M_AXIL_ARVALID !== 1'b0 || ifc.M_AXIL_RREADY !== 1'b0) begin
      failures++;
      $display("FAIL reset_ch arvalid=%b rready=%b want 0 0",
               ifc.M_AXIL_ARVALID, ifc.M_AXIL_RREADY);
    end
    checks++;
    if (ifc.M_AXIL_ARADDR !== 32'h0) begin
      failures++;
      $display("FAIL reset_araddr got=%h want 0", ifc.M_AXIL_ARADDR);
    end
    checks++;
    if (ifc.user_port_rd_ready !== 1'b1 || ifc.user_port_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_user ready=%b valid=%b want 1 0",
               ifc.user_port_rd_ready, ifc.user_port_rd_valid);
    end
    checks++;
    if (ifc.user_port_rd_data !== 32'h0 || ifc.user_port_rd_resp !== 2'b00
        || ifc.user_port_rd_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_result data=%h resp=%b tmo=%b want 0 0 0",
               ifc.user_port_rd_data, ifc.user_port_rd_resp,
               ifc.user_port_rd_timeout);
    end
    checks++;
    if (ifc.M_AXIL_ARPROT !== 3'b000) begin
      failures++;
      $display("FAIL arprot got=%b want 000", ifc.M_AXIL_ARPROT);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ifc.user_port_rd_ready !== 1'b1 || ifc.M_AXIL_ARVALID !== 1'b0) begin
      failures++;
      $display("FAIL post_reset ready=%b arvalid=%b want 1 0",
               ifc.user_port_rd_ready, ifc.M_AXIL_ARVALID);
    end
  endtask

  task automatic test_single_read();
    obs_t o;
    run_txn(32'h1000_0007, 0, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, o);
    checks++;
    if (o.araddr !== 32'h1000_0004) begin
      failures++;
      $display("FAIL single_araddr got=%h want 10000004", o.araddr);
    end
    checks++;
    if (o.lat != 3) begin
      failures++;
      $display("FAIL single_latency got=%0d want 3", o.lat);
    end
    checks++;
    if (o.data !== 32'hDEAD_BEEF || o.resp !== 2'b00) begin
      failures++;
      $display("FAIL single_data got=%h/%b want deadbeef/00", o.data, o.resp);
    end
    checks++;
    if (o.pulses != 1 || o.ready_after !== 1'b1) begin
      failures++;
      $display("FAIL single_pulse pulses=%0d ready=%b want 1 1",
               o.pulses, o.ready_after);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_txn(32'h0000_ABC1, 5, 7, 32'h1234_5678, 2'b01, 1'b0, o);
    checks++;
    if (!o.ar_stable || o.ar_high != 6 || o.araddr !== 32'h0000_ABC0) begin
      failures++;
      $display("FAIL bp_ar stable=%0d high=%0d addr=%h want 1 6 0000abc0",
               o.ar_stable, o.ar_high, o.araddr);
    end
    checks++;
    if (o.rready_early) begin
      failures++;
      $display("FAIL bp_rready_early got=1 want 0");
    end
    checks++;
    if (o.lat != 15 || o.pulses != 1) begin
      failures++;
      $display("FAIL bp_latency lat=%0d pulses=%0d want 15 1", o.lat, o.pulses);
    end
    checks++;
    if (o.data !== 32'h1234_5678 || o.resp !== 2'b01) begin
      failures++;
      $display("FAIL bp_data got=%h/%b want 12345678/01", o.data, o.resp);
    end
  endtask

  task automatic test_error_resp();
    obs_t o;
    run_txn(32'h8000_0100, 1, 2, 32'hCAFE_F00D, 2'b11, 1'b0, o);
    checks++;
    if (o.resp !== 2'b11 || o.tmo !== 1'b0) begin
      failures++;
      $display("FAIL err_resp resp=%b tmo=%b want 11 0", o.resp, o.tmo);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ifc.user_port_rd_data !== 32'hCAFE_F00D
        || ifc.user_port_rd_resp !== 2'b11) begin
      failures++;
      $display("FAIL err_hold data=%h resp=%b want cafef00d 11",
               ifc.user_port_rd_data, ifc.user_port_rd_resp);
    end
  endtask

  task automatic test_ignored_req();
    obs_t o;
    run_txn(32'h0000_4448, 2, 3, 32'h0BAD_C0DE, 2'b00, 1'b1, o);
    checks++;
    if (o.ar_hs != 1 || o.araddr !== 32'h0000_4448) begin
      failures++;
      $display("FAIL ign_ar count=%0d addr=%h want 1 00004448",
               o.ar_hs, o.araddr);
    end
    checks++;
    if (o.pulses != 1 || o.data !== 32'h0BAD_C0DE) begin
      failures++;
      $display("FAIL ign_pulse pulses=%0d data=%h want 1 0badc0de",
               o.pulses, o.data);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.M_AXIL_ARVALID !== 1'b0) begin
      failures++;
      $display("FAIL ign_no_second_ar arvalid=%b want 0", ifc.M_AXIL_ARVALID);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0] rs;
    int ad;
    int rd;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      d = $urandom;
      rs = 2'($urandom_range(0, 3));
      ad = int'($urandom_range(0, 4));
      rd = int'($urandom_range(0, 4));
      run_txn(a, ad, rd, d, rs, 1'b0, o);
      checks++;
      if (o.araddr !== a - (a % 4)) begin
        failures++;
        $display("FAIL rnd%0d_araddr got=%h want %h", i, o.araddr, a - (a % 4));
      end
      checks++;
      if (o.lat != 3 + ad + rd) begin
        failures++;
        $display("FAIL rnd%0d_latency got=%0d want %0d", i, o.lat, 3 + ad + rd);
      end
      checks++;
      if (o.data !== d || o.resp !== rs || o.tmo !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_data got=%h/%b/%b want %h/%b/0",
                 i, o.data, o.resp, o.tmo, d, rs);
      end
      checks++;
      if (o.pulses != 1 || o.ar_hs != 1 || !o.ar_stable || o.rready_early) begin
        failures++;
        $display("FAIL rnd%0d_proto pulses=%0d ar=%0d stable=%0d early=%0d want 1 1 1 0",
                 i, o.pulses, o.ar_hs, o.ar_stable, o.rready_early);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int prev;
    logic [31:0] d;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      run_txn(32'h2000_0000 + 32'(i * 4), 0, 0, d, 2'b00, 1'b0, o);
      checks++;
      if (o.data !== d) begin
        failures++;
        $display("FAIL b2b%0d_data got=%h want %h", i, o.data, d);
      end
      if (prev >= 0) begin
        checks++;
        if (o.acc_cyc - prev != 4) begin
          failures++;
          $display("FAIL b2b%0d_spacing got=%0d want 4", i, o.acc_cyc - prev);
        end
      end
      prev = o.acc_cyc;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    run_txn(32'h4000_0010, 0, 0, 32'hA5A5_5A5A, 2'b01, 1'b0, o);
    checks++;
    if (o.data !== 32'hA5A5_5A5A) begin
      failures++;
      $display("FAIL rstmid_pre got=%h want a5a55a5a", o.data);
    end
    ifc.user_port_rd_req = 1'b1;
    ifc.user_port_rd_addr = 32'h5000_0008;
    @(negedge clk);
    ifc.user_port_rd_req = 1'b0;
    ifc.M_AXIL_ARREADY = 1'b1;
    ifc.M_AXIL_RVALID = 1'b0;
    @(negedge clk);
    ifc.M_AXIL_ARREADY = 1'b0;
    checks++;
    if (ifc.M_AXIL_RREADY !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_in_data rready=%b want 1", ifc.M_AXIL_RREADY);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ifc.M_AXIL_ARVALID !== 1'b0 || ifc.M_AXIL_RREADY !== 1'b0
        || ifc.M_AXIL_ARADDR !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_axi arvalid=%b rready=%b araddr=%h want 0 0 0",
               ifc.M_AXIL_ARVALID, ifc.M_AXIL_RREADY, ifc.M_AXIL_ARADDR);
    end
    checks++;
    if (ifc.user_port_rd_ready !== 1'b1 || ifc.user_port_rd_valid !== 1'b0
        || ifc.user_port_rd_data !== 32'h0 || ifc.user_port_rd_resp !== 2'b00
        || ifc.user_port_rd_timeout !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_user ready=%b valid=%b data=%h resp=%b tmo=%b want 1 0 0 0 0",
               ifc.user_port_rd_ready, ifc.user_port_rd_valid,
               ifc.user_port_rd_data, ifc.user_port_rd_resp,
               ifc.user_port_rd_timeout);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(32'h6000_0003, 1, 1, 32'h7777_0001, 2'b00, 1'b0, o);
    checks++;
    if (o.data !== 32'h7777_0001 || o.lat != 5) begin
      failures++;
      $display("FAIL rstmid_after data=%h lat=%0d want 77770001 5", o.data, o.lat);
    end
  endtask

`ifdef AXIL_MRD_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_txn(32'h9000_0000, 100000, 0, 32'h1111_2222, 2'b00, 1'b0, o);
    checks++;
    if (o.ar_high != T || o.ar_hs != 0 || o.lat != T + 1) begin
      failures++;
      $display("FAIL tmo_timing high=%0d hs=%0d lat=%0d want %0d 0 %0d",
               o.ar_high, o.ar_hs, o.lat, T, T + 1);
    end
    checks++;
    if (o.resp !== 2'b10 || o.tmo !== 1'b1 || o.data !== 32'h0) begin
      failures++;
      $display("FAIL tmo_result resp=%b tmo=%b data=%h want 10 1 0",
               o.resp, o.tmo, o.data);
    end
    run_txn(32'h9000_0004, 0, 0, 32'h3333_4444, 2'b00, 1'b0, o);
    checks++;
    if (o.data !== 32'h3333_4444 || o.lat != 3 || o.tmo !== 1'b0) begin
      failures++;
      $display("FAIL tmo_next data=%h lat=%0d tmo=%b want 33334444 3 0",
               o.data, o.lat, o.tmo);
    end
    run_txn(32'h9000_0008, T - 1, 0, 32'h5555_6666, 2'b01, 1'b0, o);
    checks++;
    if (o.data !== 32'h5555_6666 || o.tmo !== 1'b0 || o.lat != T + 2) begin
      failures++;
      $display("FAIL tmo_limit_hs data=%h tmo=%b lat=%0d want 55556666 0 %0d",
               o.data, o.tmo, o.lat, T + 2);
    end
  endtask
`endif

  initial begin
    ifc.M_AXIL_ARREADY = 1'b0;
    ifc.M_AXIL_RVALID = 1'b0;
    ifc.M_AXIL_RDATA = '0;
    ifc.M_AXIL_RRESP = '0;
    ifc.user_port_rd_req = 1'b0;
    ifc.user_port_rd_addr = '0;
    test_reset();
    test_single_read();
    test_backpressure();
    test_error_resp();
    test_ignored_req();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef AXIL_MRD_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
